// File: rtl/uart_recv.sv
// uart_recv -- receive side of the 8N1 serial link.
//
// Recovers 1 start bit, 8 data bits (LSB first) and 1 stop bit from din.
// Each bit is sampled once, at its centre, by a period counter that is
// aligned to the falling edge of the start bit.
//
// Ports
//   clk        system clock
//   rst        asynchronous, active-high reset
//   din        serial line, idle high
//   data       last correctly received byte (LSB = first data bit)
//   valid      one-cycle pulse: data has just been updated
//   frame_err  one-cycle pulse: stop bit sampled low, byte discarded
//   busy       high while a frame is in progress (state != IDLE)
//
// Parameters
//   BIT_CYCLES clk cycles per serial bit (even, >= 4)
//   CNT_W      period counter width, 2**CNT_W > BIT_CYCLES
module uart_recv #(
  parameter int BIT_CYCLES = 16,
  parameter int CNT_W      = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       din,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  if (BIT_CYCLES < 4 || (BIT_CYCLES % 2) != 0) begin : g_bad_bit_cycles
    $error("uart_recv: BIT_CYCLES must be even and >= 4");
  end
  if ((2 ** CNT_W) <= BIT_CYCLES) begin : g_bad_cnt_w
    $error("uart_recv: CNT_W too narrow for BIT_CYCLES");
  end

  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(BIT_CYCLES / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(BIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shreg;

  // Synchronizer plus edge-detect flop, all resetting to the idle level.
  logic sync1, s, s_d;

  // The synchronizer resets to 1, so right after reset its contents do not
  // reflect din. fill_pipe marks when s carries a real sample; armed is set
  // only once a real high level has been seen. Without this, a line held low
  // through reset would look like a falling edge as soon as the reset
  // values drained out of the synchronizer.
  logic [1:0] fill_pipe;
  logic       armed;
  logic       start_edge;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b1;
      s     <= 1'b1;
      s_d   <= 1'b1;
    end else begin
      sync1 <= din;
      s     <= sync1;
      s_d   <= s;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_pipe <= 2'b00;
      armed     <= 1'b0;
    end else begin
      fill_pipe <= {fill_pipe[0], 1'b1};
      if (fill_pipe[1] && s) armed <= 1'b1;
    end
  end

  assign start_edge = armed && s_d && !s;

  // Receive FSM. valid / frame_err default low every cycle so they can only
  // ever be single-cycle pulses; busy drops in the same cycle they rise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      valid     <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (start_edge) begin
            state <= START;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end

        // Wait to the middle of the start bit; a high level there means the
        // falling edge was only a glitch.
        START: begin
          if (cnt == HALF_M1) begin
            cnt <= '0;
            if (s) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state   <= DATA;
              bit_cnt <= '0;
            end
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        // From the start-bit centre, one full period lands on each data
        // bit centre.
        DATA: begin
          if (cnt == FULL_M1) begin
            cnt            <= '0;
            shreg[bit_cnt] <= s;
            bit_cnt        <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= STOP;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        // Returning to IDLE at the stop-bit centre lets a back-to-back start
        // edge be caught at the end of the stop bit.
        STOP: begin
          if (cnt == FULL_M1) begin
            cnt   <= '0;
            state <= IDLE;
            busy  <= 1'b0;
            if (s) begin
              data  <= shreg;
              valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_recv.sv
// Bench for uart_recv: directed cases from the block's test plan followed by
// randomized frames. The driver serializes bytes on din and pushes the
// expected outcome (kind, data, arrival cycle) into a scoreboard queue; an
// independent monitor pops and compares on every valid / frame_err pulse.
module tb_uart_recv;

  localparam int B   = 16;
  localparam int H   = B / 2;
  // din edge -> 2 sync flops -> start centre (H) -> 9 more bit periods ->
  // registered pulse one cycle later.
  localparam int LAT = 2 + 1 + H + 9 * B;
  // busy spans from the cycle after the edge through the stop sample.
  localparam int BUSY_LEN = H + 9 * B;

  logic       clk = 1'b0;
  logic       rst;
  logic       din;
  logic [7:0] data;
  logic       valid, frame_err, busy;

  uart_recv #(.BIT_CYCLES(B), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .din(din),
    .data(data), .valid(valid), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit         err;
    logic [7:0] d;
    int         cyc;
  } exp_t;

  exp_t       sbq[$];
  logic [7:0] last_good;   // model: byte that data should be showing
  int         checks = 0;
  int         errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Serialize one 8N1 frame. Called at a negedge; returns at a negedge.
  task automatic send(input logic [7:0] b, input bit stop_ok, input int gap);
    logic [9:0] bits;
    exp_t e;
    bits = {stop_ok ? 1'b1 : 1'b0, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      din = bits[i];
      if (i == 0) begin
        e.err = !stop_ok;
        if (stop_ok) last_good = b;
        e.d   = last_good;
        e.cyc = cyc + LAT;
        sbq.push_back(e);
      end
      repeat (B) @(negedge clk);
    end
    din = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  task automatic glitch(input int len);
    din = 1'b0;
    repeat (len) @(negedge clk);
    din = 1'b1;
    repeat (H + 12) @(negedge clk);
  endtask

  // Monitor / scoreboard checker.
  int busy_run = 0;
  always @(negedge clk) begin
    if (rst) begin
      busy_run = 0;
    end else begin
      if (valid && frame_err)
        chk("valid_and_frame_err_exclusive", 32'd1, 32'd0);
      if (valid || frame_err) begin
        if (sbq.size() == 0) begin
          chk("unexpected_pulse", {valid, frame_err}, 32'd0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("pulse_kind_frame_err", frame_err, e.err);
          chk("pulse_kind_valid", valid, !e.err);
          chk("data", data, e.d);
          chk("pulse_cycle", cyc, e.cyc);
          chk("busy_low_at_pulse", busy, 1'b0);
          chk("busy_length", busy_run, BUSY_LEN);
        end
      end
      if (busy) busy_run = busy_run + 1;
      else busy_run = 0;
    end
  end

  initial begin
    repeat (80000) @(posedge clk);
    $display("FAIL watchdog: got cycle %0d expected completion", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] rb;
    bit         ok;
    int         gap;

    rst = 1'b1;
    din = 1'b1;
    last_good = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset_data", data, 8'h00);
    chk("reset_valid", valid, 1'b0);
    chk("reset_frame_err", frame_err, 1'b0);
    chk("reset_busy", busy, 1'b0);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // Plain frame.
    send(8'hA5, 1'b1, 20);

    // Short low glitch on an idle line: no pulse, data unchanged.
    glitch(4);
    chk("glitch_data_hold", data, 8'hA5);
    chk("glitch_busy_clear", busy, 1'b0);

    // Good frame, bad stop bit, then recovery.
    send(8'h3C, 1'b1, 10);
    send(8'h5A, 1'b0, 10);
    send(8'h81, 1'b1, 10);

    // Back-to-back, no idle gap.
    send(8'h00, 1'b1, 0);
    send(8'hFF, 1'b1, 20);
    chk("queue_drained_directed", sbq.size(), 0);

    // Reset in the middle of data bit 4.
    din = 1'b0;
    repeat (B) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      din = (8'hC3 >> i) & 1;
      repeat ((i == 4) ? H : B) @(negedge clk);
    end
    rst = 1'b1;
    #1;
    chk("midframe_rst_data", data, 8'h00);
    chk("midframe_rst_busy", busy, 1'b0);
    chk("midframe_rst_valid", valid, 1'b0);
    last_good = 8'h00;
    @(negedge clk);
    din = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    send(8'h7E, 1'b1, 20);

    // Line held low through and after reset: must not start a frame.
    din = 1'b0;
    rst = 1'b1;
    last_good = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (200) @(negedge clk);
    chk("low_line_no_busy", busy, 1'b0);
    chk("low_line_data", data, 8'h00);
    din = 1'b1;
    repeat (20) @(negedge clk);
    send(8'h11, 1'b1, 20);

    // Randomized traffic.
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 5) == 0) glitch($urandom_range(1, 5));
      rb  = 8'($urandom);
      ok  = ($urandom_range(0, 4) != 0);
      gap = ok ? $urandom_range(0, 25) : $urandom_range(2, 25);
      send(rb, ok, gap);
    end

    repeat (200) @(negedge clk);
    chk("queue_drained_final", sbq.size(), 0);
    chk("final_data", data, last_good);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
